// File: rtl/dsp_reg_file.sv
// dsp_reg_file
//   Register file for the DSP pipeline. It has two combinational read ports
//   with a same-cycle write-back bypass. A load scoreboard drives the
//   load-use interlock.
//
// Ports
//   clk, rst        single clock; asynchronous active-high reset
//   rd_addr_a/b     read indices (decode sources 1 and 2)
//   rd_use_a/b      operand actually needed by the decoding instruction
//   rd_data_a/b     read data (R0 reads 0; write-back data bypassed)
//   wb_en/addr/data write-back from the memory stage
//   issue_valid     decode issues an instruction this cycle
//   issue_is_load   issued instruction is a load
//   issue_dest      destination of the issued instruction
//   stall           load-use interlock; decode holds while 1
//   pending         scoreboard, bit i = load outstanding to Ri
module dsp_reg_file #(
   parameter int unsigned REG_WORD_LEN = 16,
   parameter int unsigned REG_ADDR_LEN = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [REG_ADDR_LEN-1:0]       rd_addr_a,
   input  logic [REG_ADDR_LEN-1:0]       rd_addr_b,
   input  logic                          rd_use_a,
   input  logic                          rd_use_b,
   output logic [REG_WORD_LEN-1:0]       rd_data_a,
   output logic [REG_WORD_LEN-1:0]       rd_data_b,
   input  logic                          wb_en,
   input  logic [REG_ADDR_LEN-1:0]       wb_addr,
   input  logic [REG_WORD_LEN-1:0]       wb_data,
   input  logic                          issue_valid,
   input  logic                          issue_is_load,
   input  logic [REG_ADDR_LEN-1:0]       issue_dest,
   output logic                          stall,
   output logic [(2**REG_ADDR_LEN)-1:0]  pending
);

   localparam int unsigned NUM_REGS = 2**REG_ADDR_LEN;

   logic [REG_WORD_LEN-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]     sb_q;
   logic [NUM_REGS-1:0]     sb_d;
   logic                    hit_a;
   logic                    hit_b;
   logic                    load_set;

   // Register array; R0 is never written, so it stays at its reset value of 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_en && (wb_addr != '0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   assign hit_a = wb_en && (wb_addr == rd_addr_a);
   assign hit_b = wb_en && (wb_addr == rd_addr_b);

   always_comb begin
      rd_data_a = regs[rd_addr_a];
      if (rd_addr_a == '0) begin
         rd_data_a = '0;
      end else if (hit_a) begin
         rd_data_a = wb_data;
      end
   end

   always_comb begin
      rd_data_b = regs[rd_addr_b];
      if (rd_addr_b == '0) begin
         rd_data_b = '0;
      end else if (hit_b) begin
         rd_data_b = wb_data;
      end
   end

   // A write-back to the awaited register releases the interlock in the same
   // cycle, because the bypass already supplies the data.
   assign stall = (rd_use_a && sb_q[rd_addr_a] && !hit_a) ||
                  (rd_use_b && sb_q[rd_addr_b] && !hit_b);

   assign load_set = issue_valid && issue_is_load && !stall;

   // The set is applied after the clear, so a new load to the register being
   // written back leaves its bit set.
   always_comb begin
      sb_d = sb_q;
      if (wb_en) begin
         sb_d[wb_addr] = 1'b0;
      end
      if (load_set) begin
         sb_d[issue_dest] = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   assign pending = sb_q;

endmodule
